gmii_loopback_inject: RTL

- Parametrised GMII loopback channel that replaces the plain wire loopback between MAC TX and RX.
- Adds a programmable-latency delay line and a one-shot fault injector. The injector can corrupt or drop one targeted frame.
- Keeps frame and injection statistics so the bench can exercise FCS, bad-frame and link-latency paths of the MAC receiver.

---
 rtl/gmii_loopback_inject.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gmii_loopback_inject.sv
// rtl/gmii_loopback_inject.sv - GMII loopback with programmable latency and one-shot frame fault injector
//
// Sits between MAC TX and MAC RX in place of a plain wire loopback.
// The TX stream goes through a one-shot injector and then a tapped delay line.
// The injector can XOR-corrupt one byte of a targeted frame, or drop that frame entirely.
//
// Ports:
//   clk, rst_n                          single clock, asynchronous active-low reset
//   gmii_txd/gmii_tx_en/gmii_tx_er      TX stream from the MAC
//   gmii_rxd/gmii_rx_dv/gmii_rx_er      delayed (and possibly modified) RX stream to the MAC
//   cfg_delay                           requested latency minus one; applied only once the line is idle
//   cfg_inj_offset/mask/er, cfg_drop_en injection setup, captured when the injector is armed
//   inj_arm                             single-cycle pulse that arms the injector
//   inj_armed                           injector is waiting for a frame or is inside its target frame
//   inj_done/inj_miss                   one-cycle outcome pulses at the end of the target frame
//   stat_tx_frames/stat_inj_frames      saturating frame counters
module gmii_loopback_inject #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY_W    = 4,
  parameter int OFFSET_W   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gmii_txd,
  input  logic                  gmii_tx_en,
  input  logic                  gmii_tx_er,
  output logic [DATA_WIDTH-1:0] gmii_rxd,
  output logic                  gmii_rx_dv,
  output logic                  gmii_rx_er,
  input  logic [DELAY_W-1:0]    cfg_delay,
  input  logic [OFFSET_W-1:0]   cfg_inj_offset,
  input  logic [DATA_WIDTH-1:0] cfg_inj_mask,
  input  logic                  cfg_inj_er,
  input  logic                  cfg_drop_en,
  input  logic                  inj_arm,
  output logic                  inj_armed,
  output logic                  inj_done,
  output logic                  inj_miss,
  output logic [CNT_W-1:0]      stat_tx_frames,
  output logic [CNT_W-1:0]      stat_inj_frames
);

  localparam int DEPTH = 2 ** DELAY_W;
  localparam int WW    = DATA_WIDTH + 2;
  localparam logic [DELAY_W:0] IDLE_FULL = (DELAY_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_DISARMED,
    S_ARMED,
    S_TARGET
  } state_t;

  state_t                state;
  logic                  tx_en_q;
  logic                  sof;
  logic [OFFSET_W-1:0]   byte_cnt;
  logic [OFFSET_W-1:0]   offset_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic                  er_s;
  logic                  drop_s;
  logic                  hit;
  logic                  in_target;
  logic [OFFSET_W-1:0]   cur_idx;
  logic                  match;
  logic [WW-1:0]         in_word;
  logic [WW-1:0]         tap;
  logic [WW-1:0]         sr [DEPTH-1];
  logic [DELAY_W:0]      idle_cnt;
  logic [DELAY_W-1:0]    cfg_delay_q;

  assign sof = gmii_tx_en & ~tx_en_q;

  // The first byte of the target frame arrives while the FSM is still ARMED,
  // so it is index 0; byte_cnt holds the index of the following byte.
  assign in_target = ((state == S_ARMED) && sof) || ((state == S_TARGET) && gmii_tx_en);
  assign cur_idx   = (state == S_TARGET) ? byte_cnt : '0;
  assign match     = in_target && !drop_s && (cur_idx == offset_s);
  assign inj_armed = (state != S_DISARMED);

  // Modified stream at the delay-line input, packed as {data, en, er}.
  always_comb begin
    in_word = {gmii_txd, gmii_tx_en, gmii_tx_er};
    if (in_target && drop_s) begin
      in_word = '0;
    end else if (match) begin
      in_word[WW-1:2] = gmii_txd ^ mask_s;
      in_word[0]      = gmii_tx_er | er_s;
    end
  end

  // Tap 0 is the live input, so the output register alone gives latency 1.
  always_comb begin
    tap = in_word;
    if (cfg_delay_q != '0) tap = sr[cfg_delay_q - DELAY_W'(1)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_DISARMED;
      byte_cnt        <= '0;
      offset_s        <= '0;
      mask_s          <= '0;
      er_s            <= 1'b0;
      drop_s          <= 1'b0;
      hit             <= 1'b0;
      inj_done        <= 1'b0;
      inj_miss        <= 1'b0;
      stat_inj_frames <= '0;
    end else begin
      inj_done <= 1'b0;
      inj_miss <= 1'b0;
      case (state)
        S_DISARMED: begin
          // An arm landing on the inj_done pulse is dropped.
          if (inj_arm && !inj_done) begin
            offset_s <= cfg_inj_offset;
            mask_s   <= cfg_inj_mask;
            er_s     <= cfg_inj_er;
            drop_s   <= cfg_drop_en;
            hit      <= 1'b0;
            state    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (sof) begin
            byte_cnt <= OFFSET_W'(1);
            hit      <= match;
            state    <= S_TARGET;
          end
        end
        S_TARGET: begin
          if (gmii_tx_en) begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + OFFSET_W'(1);
            if (match) hit <= 1'b1;
          end else begin
            state <= S_DISARMED;
            if (hit || drop_s) begin
              inj_done <= 1'b1;
              if (stat_inj_frames != '1) stat_inj_frames <= stat_inj_frames + CNT_W'(1);
            end else begin
              inj_miss <= 1'b1;
            end
          end
        end
        default: state <= S_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q        <= 1'b0;
      stat_tx_frames <= '0;
      idle_cnt       <= '0;
      cfg_delay_q    <= '0;
    end else begin
      tx_en_q <= gmii_tx_en;
      if (sof && stat_tx_frames != '1) stat_tx_frames <= stat_tx_frames + CNT_W'(1);
      if (gmii_tx_en) idle_cnt <= '0;
      else if (idle_cnt != IDLE_FULL) idle_cnt <= idle_cnt + 1'b1;
      // After DEPTH idle input cycles the line holds no frame bytes, so the tap can move safely.
      if (idle_cnt == IDLE_FULL) cfg_delay_q <= cfg_delay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) sr[i] <= '0;
      gmii_rxd   <= '0;
      gmii_rx_dv <= 1'b0;
      gmii_rx_er <= 1'b0;
    end else begin
      sr[0] <= in_word;
      for (int i = 1; i < DEPTH - 1; i++) sr[i] <= sr[i-1];
      gmii_rxd   <= tap[WW-1:2];
      gmii_rx_dv <= tap[1];
      gmii_rx_er <= tap[0];
    end
  end

endmodule
